// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode/execute pipeline: opcodes,
// instruction field positions, widths and the decode state encoding.
package pipe_pkg;

   localparam int DW = 16;
   localparam int AW = 8;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ADD   = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_AND   = 4'h3;
   localparam logic [3:0] OP_OR    = 4'h4;
   localparam logic [3:0] OP_XOR   = 4'h5;
   localparam logic [3:0] OP_SHL   = 4'h6;
   localparam logic [3:0] OP_SHR   = 4'h7;
   localparam logic [3:0] OP_LDI   = 4'h8;
   localparam logic [3:0] OP_LD    = 4'h9;
   localparam logic [3:0] OP_ST    = 4'hA;
   localparam logic [3:0] OP_BEQ   = 4'hB;
   localparam logic [3:0] OP_JMP   = 4'hC;
   localparam logic [3:0] OP_ILL_D = 4'hD;
   localparam logic [3:0] OP_ILL_E = 4'hE;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int F1_MSB  = 11;
   localparam int F1_LSB  = 8;
   localparam int F2_MSB  = 7;
   localparam int F2_LSB  = 4;
   localparam int F3_MSB  = 3;
   localparam int F3_LSB  = 0;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

endpackage

// File: rtl/reg_file.sv
// 16x16 register file: two asynchronous read ports, one synchronous write
// port, synchronous reset, r0 hardwired to zero.
module reg_file
   import pipe_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int W     = DW,
   parameter int RW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [RW-1:0] ra_addr,
   input  logic [RW-1:0] rb_addr,
   output logic [W-1:0]  ra_data,
   output logic [W-1:0]  rb_data,
   input  logic          we,
   input  logic [RW-1:0] wa,
   input  logic [W-1:0]  wd
);

   logic [W-1:0] mem [NREGS];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   // NOTE: the array is cleared in reset because registers must read zero
   // afterwards; this keeps it as flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (we && wa != '0) begin
         mem[wa] <= wd;
      end
   end

   assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
   assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decode, operand read, RAW hazard stall/bubble and HALT.
// Define DECODE_BYPASS_EN to forward wb_data on a hazard instead of stalling.
module decode_stage #(
   parameter int NREGS = 16,
   parameter int DW    = pipe_pkg::DW,
   parameter int AW    = pipe_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   curr_instr,
   input  logic          in_valid,
   input  logic [AW-1:0] in_pc,
   output logic          stall,
   input  logic          wb_en,
   input  logic [3:0]    wb_addr,
   input  logic [DW-1:0] wb_data,
   input  logic          flush,
   output logic          d_valid,
   output logic [3:0]    d_op,
   output logic [3:0]    d_rd,
   output logic [DW-1:0] d_a,
   output logic [DW-1:0] d_b,
   output logic [7:0]    d_imm,
   output logic [AW-1:0] d_target,
   output logic          d_illegal,
   output logic          halted,
   output logic [7:0]    stall_cnt
);
   import pipe_pkg::*;

   logic [3:0]    op, f1, f2, f3;
   logic [7:0]    imm;
   logic [3:0]    nx_op, nx_rd, sa, sb;
   logic [7:0]    nx_imm;
   logic [AW-1:0] nx_target;
   logic          nx_illegal, use_a, use_b, is_halt;
   logic [DW-1:0] rf_a, rf_b, opa, opb;
   logic          match_a, match_b, hazard_stall, load;
   state_t        state_q, state_d;

   assign op  = curr_instr[OP_MSB:OP_LSB];
   assign f1  = curr_instr[F1_MSB:F1_LSB];
   assign f2  = curr_instr[F2_MSB:F2_LSB];
   assign f3  = curr_instr[F3_MSB:F3_LSB];
   assign imm = curr_instr[IMM_MSB:IMM_LSB];

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      nx_op      = op;
      nx_rd      = '0;
      sa         = '0;
      sb         = '0;
      use_a      = 1'b0;
      use_b      = 1'b0;
      nx_imm     = '0;
      nx_target  = '0;
      nx_illegal = 1'b0;
      is_halt    = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            nx_rd = f1; sa = f2; sb = f3; use_a = 1'b1; use_b = 1'b1;
         end
         OP_LDI: begin nx_rd = f1; nx_imm = imm; end
         OP_LD:  begin nx_rd = f1; sa = f2; use_a = 1'b1; end
         OP_ST:  begin sa = f2; sb = f1; use_a = 1'b1; use_b = 1'b1; end
         OP_BEQ: begin
            sa = f1; sb = f2; use_a = 1'b1; use_b = 1'b1;
            nx_target = in_pc + AW'(1) + {{(AW-4){f3[3]}}, f3};
         end
         OP_JMP:   nx_target = AW'(imm);
         OP_HALT:  is_halt = 1'b1;
         OP_ILL_D, OP_ILL_E: begin nx_op = OP_NOP; nx_illegal = 1'b1; end
         default: ;
      endcase
   end

   reg_file #(.NREGS(NREGS), .W(DW), .RW(4)) u_rf (
      .clk     (clk),
      .rst     (rst),
      .ra_addr (sa),
      .rb_addr (sb),
      .ra_data (rf_a),
      .rb_data (rf_b),
      .we      (wb_en),
      .wa      (wb_addr),
      .wd      (wb_data)
   );

   // Unused source fields are forced to r0 above, so only real sources match.
   assign match_a = use_a & wb_en & (wb_addr != '0) & (wb_addr == sa);
   assign match_b = use_b & wb_en & (wb_addr != '0) & (wb_addr == sb);

`ifdef DECODE_BYPASS_EN
   assign opa          = match_a ? wb_data : rf_a;
   assign opb          = match_b ? wb_data : rf_b;
   assign hazard_stall = 1'b0;
`else
   assign opa          = rf_a;
   assign opb          = rf_b;
   assign hazard_stall = (state_q == ST_RUN) & ~flush & in_valid & (match_a | match_b);
`endif

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      stall   = 1'b0;
      case (state_q)
         ST_RUN: begin
            stall = hazard_stall;
            load  = in_valid & ~flush & ~hazard_stall;
            if (load && is_halt) state_d = ST_HALTED;
         end
         ST_HALTED: stall = 1'b1;
         default:   state_d = ST_RUN;
      endcase
   end

   assign halted = (state_q == ST_HALTED);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         d_valid   <= 1'b0;
         d_op      <= '0;
         d_rd      <= '0;
         d_a       <= '0;
         d_b       <= '0;
         d_imm     <= '0;
         d_target  <= '0;
         d_illegal <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state_q   <= state_d;
         d_valid   <= load;
         d_op      <= load ? nx_op      : '0;
         d_rd      <= load ? nx_rd      : '0;
         d_a       <= load ? opa        : '0;
         d_b       <= load ? opb        : '0;
         d_imm     <= load ? nx_imm     : '0;
         d_target  <= load ? nx_target  : '0;
         d_illegal <= load ? nx_illegal : 1'b0;
         if (hazard_stall && stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table of single-instruction decodes
// plus directed hazard, flush, HALT, reset and counter-saturation sequences.
module tb_decode_stage;

`ifdef DECODE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] curr_instr;
   logic        in_valid;
   logic [7:0]  in_pc;
   logic        stall;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        flush;
   logic        d_valid;
   logic [3:0]  d_op, d_rd;
   logic [15:0] d_a, d_b;
   logic [7:0]  d_imm, d_target;
   logic        d_illegal, halted;
   logic [7:0]  stall_cnt;

   int n_pass  = 0;
   int n_total = 0;

   decode_stage dut (
      .clk(clk), .rst(rst), .curr_instr(curr_instr), .in_valid(in_valid),
      .in_pc(in_pc), .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .flush(flush), .d_valid(d_valid), .d_op(d_op),
      .d_rd(d_rd), .d_a(d_a), .d_b(d_b), .d_imm(d_imm), .d_target(d_target),
      .d_illegal(d_illegal), .halted(halted), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] instr;
      logic [7:0]  pc;
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [15:0] a;
      logic [15:0] b;
      logic [7:0]  imm;
      logic [7:0]  tgt;
      logic        ill;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [3:0] addr, input logic [15:0] data);
      in_valid = 1'b0;
      wb_en    = 1'b1;
      wb_addr  = addr;
      wb_data  = data;
      step();
      wb_en    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      //           name      instr     pc     op    rd    a       b       imm    tgt    ill
      vecs[0]  = '{"add",    16'h1412, 8'h00, 4'h1, 4'h4, 16'd7,  16'd5,  8'h00, 8'h00, 1'b0};
      vecs[1]  = '{"sub",    16'h2521, 8'h00, 4'h2, 4'h5, 16'd5,  16'd7,  8'h00, 8'h00, 1'b0};
      vecs[2]  = '{"ld",     16'h9620, 8'h00, 4'h9, 4'h6, 16'd5,  16'd0,  8'h00, 8'h00, 1'b0};
      vecs[3]  = '{"st",     16'hA120, 8'h00, 4'hA, 4'h0, 16'd5,  16'd7,  8'h00, 8'h00, 1'b0};
      vecs[4]  = '{"beq_m2", 16'hB12E, 8'h00, 4'hB, 4'h0, 16'd7,  16'd5,  8'h00, 8'hFF, 1'b0};
      vecs[5]  = '{"beq_p3", 16'hB123, 8'h10, 4'hB, 4'h0, 16'd7,  16'd5,  8'h00, 8'h14, 1'b0};
      vecs[6]  = '{"beq_wr", 16'hB127, 8'hFE, 4'hB, 4'h0, 16'd7,  16'd5,  8'h00, 8'h06, 1'b0};
      vecs[7]  = '{"jmp",    16'hC0AB, 8'h33, 4'hC, 4'h0, 16'd0,  16'd0,  8'h00, 8'hAB, 1'b0};
      vecs[8]  = '{"nop",    16'h0FFF, 8'h00, 4'h0, 4'h0, 16'd0,  16'd0,  8'h00, 8'h00, 1'b0};
      vecs[9]  = '{"ill_d",  16'hD123, 8'h00, 4'h0, 4'h0, 16'd0,  16'd0,  8'h00, 8'h00, 1'b1};
      vecs[10] = '{"ill_e",  16'hE456, 8'h00, 4'h0, 4'h0, 16'd0,  16'd0,  8'h00, 8'h00, 1'b1};
      vecs[11] = '{"add_r0", 16'h1701, 8'h00, 4'h1, 4'h7, 16'd0,  16'd7,  8'h00, 8'h00, 1'b0};

      rst = 1'b1; curr_instr = '0; in_valid = 1'b0; in_pc = '0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
      step(); step();
      check("rst.d_valid", d_valid, 0);
      check("rst.d_op", d_op, 0);
      check("rst.d_a", d_a, 0);
      check("rst.d_target", d_target, 0);
      check("rst.stall", stall, 0);
      check("rst.halted", halted, 0);
      check("rst.stall_cnt", stall_cnt, 0);
      rst = 1'b0;

      // LDI r3,0x5A
      curr_instr = 16'h835A; in_valid = 1'b1;
      step();
      check("ldi.d_valid", d_valid, 1);
      check("ldi.d_op", d_op, 8);
      check("ldi.d_rd", d_rd, 3);
      check("ldi.d_imm", d_imm, 8'h5A);
      check("ldi.d_a", d_a, 0);

      write_reg(4'd1, 16'd7);
      write_reg(4'd2, 16'd5);

      for (int i = 0; i < 12; i++) begin
         curr_instr = vecs[i].instr;
         in_pc      = vecs[i].pc;
         in_valid   = 1'b1;
         #1;
         check($sformatf("%s.stall", vecs[i].name), stall, 0);
         step();
         check($sformatf("%s.d_valid", vecs[i].name), d_valid, 1);
         check($sformatf("%s.d_op", vecs[i].name), d_op, vecs[i].op);
         check($sformatf("%s.d_rd", vecs[i].name), d_rd, vecs[i].rd);
         check($sformatf("%s.d_a", vecs[i].name), d_a, vecs[i].a);
         check($sformatf("%s.d_b", vecs[i].name), d_b, vecs[i].b);
         check($sformatf("%s.d_imm", vecs[i].name), d_imm, vecs[i].imm);
         check($sformatf("%s.d_target", vecs[i].name), d_target, vecs[i].tgt);
         check($sformatf("%s.d_illegal", vecs[i].name), d_illegal, vecs[i].ill);
      end
      in_pc = '0;

      // RAW hazard: ADD r4,r1,r2 while r2 <- 9 is written back
      curr_instr = 16'h1412; in_valid = 1'b1;
      wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'd9;
      #1;
      check("haz.stall", stall, BYPASS ? 0 : 1);
      step();
      check("haz.d_valid", d_valid, BYPASS ? 1 : 0);
      check("haz.stall_cnt", stall_cnt, BYPASS ? 0 : 1);
      wb_en = 1'b0;
      #1;
      check("haz.stall_after", stall, 0);
      step();
      check("haz2.d_valid", d_valid, 1);
      check("haz2.d_a", d_a, 7);
      check("haz2.d_b", d_b, 9);

      // write to a field LDI does not read: no hazard
      curr_instr = 16'h8520; wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'd9;
      #1;
      check("ldi_nohaz.stall", stall, 0);
      step();
      check("ldi_nohaz.d_imm", d_imm, 8'h20);
      check("ldi_nohaz.d_valid", d_valid, 1);

      // write to r0 is neither a hazard nor stored
      curr_instr = 16'h1401; wb_addr = 4'd0; wb_data = 16'h1234;
      #1;
      check("r0w.stall", stall, 0);
      step();
      check("r0w.d_a", d_a, 0);
      check("r0w.d_b", d_b, 7);
      wb_en = 1'b0;
      step();
      check("r0rd.d_a", d_a, 0);

      // flush beats hazard: no stall, no count
      curr_instr = 16'h1412; wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'd7; flush = 1'b1;
      #1;
      check("flhaz.stall", stall, 0);
      step();
      check("flhaz.d_valid", d_valid, 0);
      check("flhaz.stall_cnt", stall_cnt, BYPASS ? 0 : 1);
      wb_en = 1'b0;

      // flushed HALT is dropped
      curr_instr = 16'hF000;
      step();
      check("flhalt.d_valid", d_valid, 0);
      check("flhalt.halted", halted, 0);
      flush = 1'b0;

      // HALT accepted
      step();
      check("halt.d_valid", d_valid, 1);
      check("halt.d_op", d_op, 4'hF);
      check("halt.halted", halted, 1);
      check("halt.stall", stall, 1);
      curr_instr = 16'h1412;
      step();
      check("halted.d_valid", d_valid, 0);
      check("halted.halted", halted, 1);
      check("halted.stall", stall, 1);

      rst = 1'b1; in_valid = 1'b0;
      step();
      rst = 1'b0;
      #1;
      check("rst2.halted", halted, 0);
      check("rst2.stall", stall, 0);
      check("rst2.d_valid", d_valid, 0);
      check("rst2.stall_cnt", stall_cnt, 0);
      in_valid = 1'b1;
      step();
      check("rst2.d_valid_add", d_valid, 1);
      check("rst2.d_a", d_a, 0);
      check("rst2.d_b", d_b, 0);

      // persistent hazard drives stall_cnt to saturation
      write_reg(4'd1, 16'd3);
      curr_instr = 16'h1412; in_valid = 1'b1;
      wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'd1;
      repeat (300) step();
      check("sat.stall_cnt", stall_cnt, BYPASS ? 0 : 255);
      check("sat.d_valid", d_valid, BYPASS ? 1 : 0);
      wb_en = 1'b0; in_valid = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second stage of the 3-stage pipeline (fetch → decode → execute). Accepts one 16-bit instruction per cycle from the fetch unit and decodes it. Reads two operands from the 16×16 register file it owns. Registers a decoded bundle for execute, stalls fetch on read-after-write hazards and on HALT, and takes register writeback and branch flush back from execute.

## Interface
Parameters:
- `NREGS`, 16: register count; r0 reads as 0, writes to r0 are ignored.
- `DW`, 16: data and instruction width.
- `AW`, 8: instruction address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `curr_instr`  in  16  instruction from fetch.
- `in_valid`  in  1  `curr_instr` is valid this cycle.
- `in_pc`  in  8  address of `curr_instr`.
- `stall`  out  1  fetch holds its address and instruction this cycle.
- `wb_en` / `wb_addr` / `wb_data`  in  1/4/16  register write from execute, committed at the edge.
- `flush`  in  1  taken branch or jump in execute; kill decode.
- `d_valid`, `d_op[3:0]`, `d_rd[3:0]`, `d_a[15:0]`, `d_b[15:0]`, `d_imm[7:0]`, `d_target[7:0]`, `d_illegal`  out  registered bundle to execute.
- `halted`  out  1  HALT has been decoded.
- `stall_cnt`  out  8  saturating count of hazard stall cycles.

## Operation
- Fields: op=[15:12], F1=[11:8], F2=[7:4], F3=[3:0], imm=[7:0].
- ALU ops 1–7 (ADD, SUB, AND, OR, XOR, SHL, SHR): rd=F1, a=R[F2], b=R[F3].
- 8 LDI: rd=F1, d_imm=imm, no sources.
- 9 LD: rd=F1, a=R[F2].
- A ST: a=R[F2] (address), b=R[F1] (data).
- B BEQ: a=R[F1], b=R[F2], d_target = in_pc + 1 + sext(F3), modulo 256.
- C JMP: d_target = imm.
- 0 NOP: no sources.
- F HALT: no sources.
- Opcodes D and E: emitted as NOP with `d_illegal`=1.
- Unused bundle fields are 0.
- States: RUN and HALTED.
  - HALT accepted in RUN → HALTED.
  - HALTED: `stall`=1, `halted`=1, `d_valid`=0 until `rst`.
- Hazard: `in_valid` & `wb_en` & `wb_addr`≠0 & `wb_addr` equals a source field the opcode uses.
- Priority each cycle:
  1. `rst`: register file, bundle, state and counter cleared.
  2. `flush`: `d_valid`←0, incoming instruction dropped (including HALT), `stall`=0.
  3. Hazard handling (see Configuration).
  4. Normal decode: `d_valid`←`in_valid`.
- Writeback is always committed, even during `flush`, stall or HALTED.
- `stall_cnt` increments on each hazard-stall cycle and saturates at 255.

## Timing
- Reset values: all `d_*`=0, `stall`=0, `halted`=0, `stall_cnt`=0, all registers=0.
- Latency: instruction present at edge N → bundle visible after edge N.
- `stall` is combinational from the current inputs and state.
- While `stall`=1, fetch presents the same instruction next cycle.
- A hazard stall lasts exactly one cycle. The write commits at that edge and a bubble is inserted (`d_valid`←0).
- `flush` and a hazard in the same cycle: `flush` wins, `stall`=0, no count.

## Configuration
- `DECODE_BYPASS_EN` defined:
  - A hazard forwards `wb_data` into the matching operand(s).
  - No stall, no bubble; `stall_cnt` stays 0.
- Undefined: a hazard causes the one-cycle stall and bubble described above.
- Both builds write the register file identically.

## Structure
- Shared package `pipe_pkg`:
  - opcode localparams OP_NOP..OP_HALT;
  - field bit positions;
  - width constants DW/AW;
  - state encoding.
- Sub-module `reg_file`:
  - 16×16 registers;
  - two async read ports, one sync write port;
  - sync reset;
  - r0 hardwired to 0.

## Test plan
- Reset, then LDI r3,0x5A (0x835A) → `d_valid`=1, `d_op`=8, `d_rd`=3, `d_imm`=0x5A.
- Preload r1=7, r2=5, then ADD r4,r1,r2 (0x1412) → `d_a`=7, `d_b`=5, no stall.
- `wb_en` r2←9 in the same cycle as ADD r4,r1,r2:
  - bypass build: `d_b`=9, `stall`=0;
  - non-bypass build: `stall`=1 for one cycle, bubble, then `d_b`=9, `stall_cnt`=1.
- BEQ r1,r2,-2 (0xB12E) at `in_pc`=0x00 → `d_target`=0xFF (wrap).
- `flush` asserted with HALT (0xF000) presented → `d_valid`=0, `halted` stays 0; the next HALT gives `halted`=1 and `stall`=1 until `rst`.
- Opcode 0xD123 → `d_illegal`=1, `d_op`=0; write to r0 → r0 still reads 0.
